// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing constants, sync window helpers and coordinate type.
package vga_timing_pkg;
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  typedef logic [9:0] coord_t;
  function automatic coord_t sync_start(int active, int fp);
    return coord_t'(active + fp);
  endfunction
  function automatic coord_t sync_end(int active, int fp, int sync);
    return coord_t'(active + fp + sync - 1);
  endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis; wraps at i_last and flags sync/active windows of the next count.
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_en,
  input  coord_t i_last,
  input  coord_t i_sync_start,
  input  coord_t i_sync_end,
  input  coord_t i_active,
  output coord_t o_count,
  output logic   o_wrap,
  output logic   o_in_sync,
  output logic   o_in_active
);
  coord_t r_count;
  coord_t w_next;
  logic   w_last;
  assign w_last      = r_count == i_last;
  assign o_wrap      = i_en && w_last;
  assign w_next      = !i_en ? r_count : w_last ? '0 : r_count + 1'b1;
  // Window flags look at the next count so registered outputs line up with the count
  assign o_in_sync   = w_next >= i_sync_start && w_next <= i_sync_end;
  assign o_in_active = w_next < i_active;
  assign o_count     = r_count;
  always_ff @(posedge clk) r_count <= rst ? '0 : w_next;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: single VGA timing source (pixel enable, x/y, syncs, blanking, line/frame strobes).
// Define VGA_SYNC_DELAY_EN to delay hsync/vsync/video_on/blank_n by one pixel tick to match RGB registers.
module vga_sync_gen #(
  parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP     = vga_timing_pkg::H_FP,
  parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int H_BP     = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP     = vga_timing_pkg::V_FP,
  parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int V_BP     = vga_timing_pkg::V_BP,
  parameter int SYNC_POL = 0
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       blank_n,
  output logic       sync_n,
  output logic       line_tick,
  output logic       frame_tick
);
  import vga_timing_pkg::*;
  localparam int   HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic SP = SYNC_POL != 0;
  if (HT > 1024 || VT > 1024) begin : g_bad_total
    $error("vga_sync_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  logic r_ph, r_hsync, r_vsync, r_video_on, r_line_tick, r_frame_tick;
  logic w_hwrap, w_vwrap, w_hsync_on, w_vsync_on, w_hact, w_vact;
  vga_axis_counter u_h (
    .clk(clk_50MHz), .rst(reset), .i_en(r_ph),
    .i_last(coord_t'(HT - 1)),
    .i_sync_start(sync_start(H_ACTIVE, H_FP)),
    .i_sync_end(sync_end(H_ACTIVE, H_FP, H_SYNC)),
    .i_active(coord_t'(H_ACTIVE)),
    .o_count(x), .o_wrap(w_hwrap), .o_in_sync(w_hsync_on), .o_in_active(w_hact)
  );
  vga_axis_counter u_v (
    .clk(clk_50MHz), .rst(reset), .i_en(w_hwrap),
    .i_last(coord_t'(VT - 1)),
    .i_sync_start(sync_start(V_ACTIVE, V_FP)),
    .i_sync_end(sync_end(V_ACTIVE, V_FP, V_SYNC)),
    .i_active(coord_t'(V_ACTIVE)),
    .o_count(y), .o_wrap(w_vwrap), .o_in_sync(w_vsync_on), .o_in_active(w_vact)
  );
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_ph         <= 1'b0;
      r_hsync      <= ~SP;
      r_vsync      <= ~SP;
      r_video_on   <= 1'b1;
      r_line_tick  <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_ph         <= ~r_ph;
      r_hsync      <= w_hsync_on ? SP : ~SP;
      r_vsync      <= w_vsync_on ? SP : ~SP;
      r_video_on   <= w_hact && w_vact;
      r_line_tick  <= w_hwrap;
      r_frame_tick <= w_vwrap;
    end
  end
  assign p_tick     = r_ph;
  assign sync_n     = 1'b0;
  assign line_tick  = r_line_tick;
  assign frame_tick = r_frame_tick;
`ifdef VGA_SYNC_DELAY_EN
  logic r_hsync_d, r_vsync_d, r_video_on_d;
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      r_hsync_d    <= ~SP;
      r_vsync_d    <= ~SP;
      r_video_on_d <= 1'b1;
    end else if (r_ph) begin
      r_hsync_d    <= r_hsync;
      r_vsync_d    <= r_vsync;
      r_video_on_d <= r_video_on;
    end
  end
  assign hsync    = r_hsync_d;
  assign vsync    = r_vsync_d;
  assign video_on = r_video_on_d;
  assign blank_n  = r_video_on_d;
`else
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign video_on = r_video_on;
  assign blank_n  = r_video_on;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized bench checking three timing configurations against a pixel-count model.
module tb_vga_sync_gen;
  logic clk_50MHz = 1'b0;
  logic reset = 1'b1;
  always #10 clk_50MHz = ~clk_50MHz;
  logic       pt[3], hs[3], vs[3], vo[3], bn[3], sn[3], lt[3], ft[3];
  logic [9:0] xs[3], ys[3];
  logic [27:0] got[3];
  int   ha[3] = '{640, 8, 8};
  int   hf[3] = '{16, 2, 2};
  int   hw[3] = '{96, 3, 3};
  int   hb[3] = '{48, 2, 2};
  int   va[3] = '{480, 5, 5};
  int   vf[3] = '{10, 1, 1};
  int   vw[3] = '{2, 2, 2};
  int   vb[3] = '{33, 2, 2};
  logic pol[3] = '{1'b0, 1'b0, 1'b1};
  int   n = 0;
  logic ph = 1'b0;
  logic ticked = 1'b0;
  int   tests = 0;
  int   fails = 0;

  vga_sync_gen u_d0 (
    .clk_50MHz(clk_50MHz), .reset(reset), .p_tick(pt[0]), .x(xs[0]), .y(ys[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]), .blank_n(bn[0]), .sync_n(sn[0]),
    .line_tick(lt[0]), .frame_tick(ft[0])
  );
  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2)) u_d1 (
    .clk_50MHz(clk_50MHz), .reset(reset), .p_tick(pt[1]), .x(xs[1]), .y(ys[1]),
    .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]), .blank_n(bn[1]), .sync_n(sn[1]),
    .line_tick(lt[1]), .frame_tick(ft[1])
  );
  vga_sync_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
                 .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1)) u_d2 (
    .clk_50MHz(clk_50MHz), .reset(reset), .p_tick(pt[2]), .x(xs[2]), .y(ys[2]),
    .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]), .blank_n(bn[2]), .sync_n(sn[2]),
    .line_tick(lt[2]), .frame_tick(ft[2])
  );
  for (genvar k = 0; k < 3; k++) begin : g_got
    assign got[k] = {pt[k], xs[k], ys[k], hs[k], vs[k], vo[k], bn[k], sn[k], lt[k], ft[k]};
  end

  // n counts pixel ticks since reset; position, windows and strobes all follow from it
  function automatic logic [27:0] model(int k);
    int ht = ha[k] + hf[k] + hw[k] + hb[k];
    int vt = va[k] + vf[k] + vw[k] + vb[k];
    int nd = n;
    int dx, dy;
    logic hsa, vsa, vid;
`ifdef VGA_SYNC_DELAY_EN
    nd = n > 0 ? n - 1 : 0;
`endif
    dx  = nd % ht;
    dy  = (nd / ht) % vt;
    hsa = dx >= ha[k] + hf[k] && dx < ha[k] + hf[k] + hw[k];
    vsa = dy >= va[k] + vf[k] && dy < va[k] + vf[k] + vw[k];
    vid = dx < ha[k] && dy < va[k];
    return {ph, 10'(n % ht), 10'((n / ht) % vt), hsa ? pol[k] : ~pol[k], vsa ? pol[k] : ~pol[k],
            vid, vid, 1'b0, ticked && n % ht == 0, ticked && n % (ht * vt) == 0};
  endfunction

  task automatic step();
    @(posedge clk_50MHz);
    ticked = !reset && ph;
    if (reset) begin
      n  = 0;
      ph = 1'b0;
    end else begin
      n  = n + int'(ph);
      ph = ~ph;
    end
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) begin
      step();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== model(k)) begin
          fails++;
          $display("FAIL reset dut%0d got=%h exp=%h", k, got[k], model(k));
        end
      end
    end
    tests++;
    if (got[0] !== 28'h78) begin
      fails++;
      $display("FAIL reset_const dut0 got=%h exp=%h", got[0], 28'h78);
    end
    tests++;
    if (got[2] !== 28'h18) begin
      fails++;
      $display("FAIL reset_const dut2 got=%h exp=%h", got[2], 28'h18);
    end
    reset = 1'b0;
    step();
    tests++;
    if (pt[0] !== 1'b1) begin
      fails++;
      $display("FAIL first_ptick got=%b exp=1", pt[0]);
    end
    repeat (4) begin
      step();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== model(k)) begin
          fails++;
          $display("FAIL post_reset dut%0d n=%0d got=%h exp=%h", k, n, got[k], model(k));
        end
      end
    end
  endtask

  task automatic test_line();
    int hlow = 0, lines = 0, first_x = -1;
`ifdef VGA_SYNC_DELAY_EN
    int exp_first = 657;
`else
    int exp_first = 656;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (1700) begin
      step();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== model(k)) begin
          fails++;
          $display("FAIL line dut%0d n=%0d got=%h exp=%h", k, n, got[k], model(k));
        end
      end
      if (pt[0] && !hs[0]) hlow++;
      if (!hs[0] && first_x < 0) first_x = int'(xs[0]);
      if (lt[0]) lines++;
    end
    tests++;
    if (hlow !== 96) begin
      fails++;
      $display("FAIL hsync_width got=%0d exp=96", hlow);
    end
    tests++;
    if (first_x !== exp_first) begin
      fails++;
      $display("FAIL hsync_start got=%0d exp=%0d", first_x, exp_first);
    end
    tests++;
    if (lines !== 1) begin
      fails++;
      $display("FAIL line_tick_count got=%0d exp=1", lines);
    end
  endtask

  task automatic test_frame();
    int frames = 0, vis = 0, vlow = 0;
`ifdef VGA_SYNC_DELAY_EN
    int exp_vis = 41;
`else
    int exp_vis = 40;
`endif
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      step();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== model(k)) begin
          fails++;
          $display("FAIL frame dut%0d n=%0d got=%h exp=%h", k, n, got[k], model(k));
        end
      end
      if (ft[1]) frames++;
      if (c <= 300 && pt[1] && vo[1]) vis++;
      if (c <= 300 && pt[1] && !vs[1]) vlow++;
    end
    tests++;
    if (frames !== 2) begin
      fails++;
      $display("FAIL frame_tick_count got=%0d exp=2", frames);
    end
    tests++;
    if (vis !== exp_vis) begin
      fails++;
      $display("FAIL visible_ticks got=%0d exp=%0d", vis, exp_vis);
    end
    tests++;
    if (vlow !== 30) begin
      fails++;
      $display("FAIL vsync_ticks got=%0d exp=30", vlow);
    end
  endtask

  task automatic test_mid_reset();
    repeat (6) begin
      repeat ($urandom_range(20, 4000)) begin
        step();
        for (int k = 0; k < 3; k++) begin
          tests++;
          if (got[k] !== model(k)) begin
            fails++;
            $display("FAIL pre_reset dut%0d n=%0d got=%h exp=%h", k, n, got[k], model(k));
          end
        end
      end
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) step();
      tests++;
      if (got[0] !== 28'h78) begin
        fails++;
        $display("FAIL mid_reset dut0 got=%h exp=%h", got[0], 28'h78);
      end
      reset = 1'b0;
      repeat (320) begin
        step();
        for (int k = 0; k < 3; k++) begin
          tests++;
          if (got[k] !== model(k)) begin
            fails++;
            $display("FAIL resume dut%0d n=%0d got=%h exp=%h", k, n, got[k], model(k));
          end
        end
      end
    end
  endtask

  task automatic test_random();
    repeat (20000) begin
      reset = $urandom_range(0, 1499) == 0;
      step();
      for (int k = 0; k < 3; k++) begin
        tests++;
        if (got[k] !== model(k)) begin
          fails++;
          $display("FAIL random dut%0d n=%0d got=%h exp=%h", k, n, got[k], model(k));
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
